stream_merge_2to1: RTL and testbench

- Merges two 32-bit valid/ready streams (port A, port B) into one registered output stream. It is the collecting end that reassembles traffic split by the 1-to-2 steering stage.
- Arbitration is round-robin at packet granularity. Once a source is granted, it holds the output until it delivers a beat with last=1.
- Sits between the two execution/lane return paths and the single shared writeback/consumer port.
- Each output beat carries a source tag.

---
 rtl/mux_pkg.sv | 17 +
 rtl/stream_merge_2to1_rr_arb2.sv | 74 +++++++
 rtl/stream_merge_2to1.sv | 107 ++++++++++
 tb/tb_stream_merge_2to1.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 2-to-1 stream merge.
// Holds the source tag encoding, the arbiter state encoding and the
// default beat width used by stream_merge_2to1 and rr_arb2.
package mux_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/stream_merge_2to1_rr_arb2.sv
// rr_arb2: packet-granular round-robin arbiter for two sources.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   a_valid_i        source A has a beat
//   b_valid_i        source B has a beat
//   acc_i            a beat from the granted source is accepted this cycle
//   acc_last_i       the accepted beat closes its packet
//   grant_a_o        source A owns the output
//   grant_b_o        source B owns the output
module rr_arb2
  import mux_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic acc_i,
  input  logic acc_last_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  arb_state_e state_q, state_d;
  logic       prio_q, prio_d;

  // A locked source keeps the grant even while idle so the other port
  // cannot slip a beat into the middle of its packet.
  always_comb begin
    grant_a_o = 1'b0;
    grant_b_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid_i && b_valid_i) begin
          grant_a_o = (prio_q == SRC_A);
          grant_b_o = (prio_q == SRC_B);
        end else begin
          grant_a_o = a_valid_i;
          grant_b_o = b_valid_i;
        end
      end
      LOCK_A:  grant_a_o = 1'b1;
      LOCK_B:  grant_b_o = 1'b1;
      default: ;
    endcase
  end

  // Only the granted source can be accepted, so grant_b_o names the
  // source of the accepted beat.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (acc_i) begin
      if (acc_last_i) begin
        state_d = IDLE;
        prio_d  = grant_b_o ? SRC_A : SRC_B;
      end else begin
        state_d = grant_b_o ? LOCK_B : LOCK_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= FIRST_PRIO;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: rtl/stream_merge_2to1.sv
// stream_merge_2to1: merges two valid/ready streams into one registered
// output stream, arbitrating round-robin per packet and tagging each
// output beat with its source.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   a_valid/a_data/a_last      port A input beat, a_ready accepts it
//   b_valid/b_data/b_last      port B input beat, b_ready accepts it
//   o_valid/o_data/o_last      registered output beat
//   o_src                      source of the output beat (0 = A, 1 = B)
//   o_ready                    downstream accepts the output beat
module stream_merge_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_src,
  input  logic             o_ready
);

  logic             grant_a, grant_b;
  logic             load_en;
  logic             a_acc, b_acc, acc;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_last_q, o_last_d;
  logic             o_src_q, o_src_d;

  rr_arb2 #(
    .FIRST_PRIO(FIRST_PRIO)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .acc_i     (acc),
    .acc_last_i(sel_last),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  // The output register can take a new beat when empty or being drained.
  assign load_en = ~o_valid_q | o_ready;

  // Readies are forced low during reset so no beat is taken while the
  // lock state is being cleared.
  assign a_ready = grant_a & load_en & ~reset;
  assign b_ready = grant_b & load_en & ~reset;

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;
  assign acc   = a_acc | b_acc;

  assign sel_data = b_acc ? b_data : a_data;
  assign sel_last = b_acc ? b_last : a_last;

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_src_d   = o_src_q;
    if (load_en) begin
      o_valid_d = acc;
      if (acc) begin
        o_data_d = sel_data;
        o_last_d = sel_last;
        o_src_d  = b_acc ? SRC_B : SRC_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_src_q   <= o_src_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_src   = o_src_q;

endmodule

// File: tb/tb_stream_merge_2to1.sv
module tb_stream_merge_2to1;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_last, a_ready;
  logic [31:0] a_data;
  logic        b_valid, b_last, b_ready;
  logic [31:0] b_data;
  logic        o_valid, o_last, o_src, o_ready;
  logic [31:0] o_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];

  stream_merge_2to1 #(.WIDTH(32), .FIRST_PRIO(1'b0)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_last (a_last),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_last (b_last),
    .b_ready(b_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_last (o_last),
    .o_src  (o_src),
    .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int          ia, ib;
    logic [15:0] seq_a, seq_b;
    logic        a_acc, b_acc, o_acc;
    logic        a_open, b_open, in_pkt, pkt_src, drain;
    logic [32:0] exp_beat;

    reset = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    o_ready = 1'b1;

    // ---- reset state, readies gated by reset ----
    tick();
    tick();
    a_valid = 1'b1; a_data = 32'h1111_1111; a_last = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_data", o_data, 32'h0);
    check("rst_o_last", o_last, 1'b0);
    check("rst_o_src", o_src, 1'b0);

    // ---- single beat from A ----
    tick();
    reset = 1'b0;
    #1;
    check("t1_a_ready", a_ready, 1'b1);
    check("t1_b_ready", b_ready, 1'b0);
    tick();
    a_valid = 1'b0;
    check("t1_o_valid", o_valid, 1'b1);
    check("t1_o_data", o_data, 32'h1111_1111);
    check("t1_o_src", o_src, 1'b0);
    check("t1_o_last", o_last, 1'b1);
    // prio now B: with both valid B must win
    a_valid = 1'b1; a_data = 32'hA0; a_last = 1'b1;
    b_valid = 1'b1; b_data = 32'hB0; b_last = 1'b1;
    #1;
    check("t1_prio_b_ready", b_ready, 1'b1);
    check("t1_prio_a_ready", a_ready, 1'b0);

    // ---- alternating single-beat packets ----
    do_reset();
    o_ready = 1'b1;
    ia = 0; ib = 0;
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1; a_last = 1'b1; a_data = 32'hA0 + ia;
      b_valid = 1'b1; b_last = 1'b1; b_data = 32'hB0 + ib;
      #1;
      check("alt_excl", a_ready & b_ready, 1'b0);
      check("alt_a_ready", a_ready, (k % 2 == 0));
      if (a_ready) ia++;
      if (b_ready) ib++;
      tick();
      check("alt_o_valid", o_valid, 1'b1);
      check("alt_o_data", o_data, (k % 2 == 0) ? 32'hA0 + k / 2 : 32'hB0 + k / 2);
      check("alt_o_src", o_src, (k % 2 == 1));
    end

    // ---- 3-beat A packet with B waiting, A idles mid-packet ----
    do_reset();
    o_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'hA1; a_last = 1'b0;
    b_valid = 1'b1; b_data = 32'hB0; b_last = 1'b1;
    #1;
    check("pk_c0_a_ready", a_ready, 1'b1);
    check("pk_c0_b_ready", b_ready, 1'b0);
    tick();
    check("pk_o_A1", o_data, 32'hA1);
    check("pk_o_A1_last", o_last, 1'b0);
    a_valid = 1'b0;
    #1;
    check("pk_idle_b_ready", b_ready, 1'b0);
    tick();
    check("pk_drain_o_valid", o_valid, 1'b0);
    a_valid = 1'b1; a_data = 32'hA2; a_last = 1'b0;
    #1;
    check("pk_c2_b_ready", b_ready, 1'b0);
    tick();
    check("pk_o_A2", o_data, 32'hA2);
    a_data = 32'hA3; a_last = 1'b1;
    #1;
    check("pk_c3_b_ready", b_ready, 1'b0);
    tick();
    check("pk_o_A3", o_data, 32'hA3);
    check("pk_o_A3_last", o_last, 1'b1);
    a_valid = 1'b0;
    #1;
    check("pk_c4_b_ready", b_ready, 1'b1);
    tick();
    b_valid = 1'b0;
    check("pk_o_B0", o_data, 32'hB0);
    check("pk_o_B0_src", o_src, 1'b1);

    // ---- back-pressure hold ----
    do_reset();
    o_ready = 1'b0;
    a_valid = 1'b1; a_data = 32'hDEAD_BEEF; a_last = 1'b1;
    #1;
    check("bp_load_a_ready", a_ready, 1'b1);
    tick();
    check("bp_o_valid", o_valid, 1'b1);
    check("bp_o_data", o_data, 32'hDEAD_BEEF);
    a_data = 32'h1234_5678;
    b_valid = 1'b1; b_data = 32'hB1; b_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_a_ready", a_ready, 1'b0);
      check("bp_b_ready", b_ready, 1'b0);
      tick();
      check("bp_o_hold", o_data, 32'hDEAD_BEEF);
    end
    o_ready = 1'b1;
    #1;
    check("bp_rel_b_ready", b_ready, 1'b1);
    check("bp_rel_a_ready", a_ready, 1'b0);
    tick();
    check("bp_next_valid", o_valid, 1'b1);
    check("bp_next_data", o_data, 32'hB1);
    check("bp_next_src", o_src, 1'b1);
    a_valid = 1'b0; b_valid = 1'b0;

    // ---- reset during LOCK_B ----
    do_reset();
    o_ready = 1'b1;
    b_valid = 1'b1; b_data = 32'hB5; b_last = 1'b0;
    tick();
    check("rl_o_B5", o_data, 32'hB5);
    b_valid = 1'b0;
    a_valid = 1'b1; a_data = 32'hA7; a_last = 1'b1;
    o_ready = 1'b0;
    #1;
    check("rl_o_valid_held", o_valid, 1'b1);
    check("rl_lock_a_ready", a_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("rl_rst_a_ready", a_ready, 1'b0);
    tick();
    check("rl_o_valid_cleared", o_valid, 1'b0);
    reset = 1'b0;
    #1;
    check("rl_idle_a_ready", a_ready, 1'b1);
    tick();
    check("rl_o_A7", o_data, 32'hA7);
    check("rl_o_A7_src", o_src, 1'b0);
    check("rl_o_A7_valid", o_valid, 1'b1);

    // ---- random traffic against scoreboard ----
    do_reset();
    seq_a = '0; seq_b = '0;
    a_acc = 1'b0; b_acc = 1'b0;
    a_open = 1'b0; b_open = 1'b0;
    in_pkt = 1'b0; pkt_src = 1'b0;
    for (int cyc = 0; cyc < 2300; cyc++) begin
      drain = (cyc >= 2000);
      if (!a_valid || a_acc) begin
        if (drain) begin
          a_valid = a_open; a_last = 1'b1;
        end else begin
          a_valid = ($urandom_range(0, 3) != 0);
          a_last  = ($urandom_range(0, 2) == 0);
        end
        a_data = {16'hAAAA, seq_a};
      end
      if (!b_valid || b_acc) begin
        if (drain) begin
          b_valid = b_open; b_last = 1'b1;
        end else begin
          b_valid = ($urandom_range(0, 3) != 0);
          b_last  = ($urandom_range(0, 2) == 0);
        end
        b_data = {16'hBBBB, seq_b};
      end
      o_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      #2;
      a_acc = a_valid & a_ready;
      b_acc = b_valid & b_ready;
      o_acc = o_valid & o_ready;
      check("rnd_ready_excl", a_ready & b_ready, 1'b0);
      if (a_acc) begin
        qa.push_back({a_last, a_data});
        seq_a++;
        a_open = !a_last;
      end
      if (b_acc) begin
        qb.push_back({b_last, b_data});
        seq_b++;
        b_open = !b_last;
      end
      if (o_acc) begin
        if (in_pkt) check("rnd_interleave", o_src, pkt_src);
        if ((o_src ? qb.size() : qa.size()) == 0) begin
          check("rnd_extra_beat", {o_last, o_data}, 33'h0_DEAD_0000);
        end else begin
          exp_beat = o_src ? qb.pop_front() : qa.pop_front();
          check("rnd_beat", {o_last, o_data}, exp_beat);
        end
        in_pkt  = !o_last;
        pkt_src = o_src;
      end
      tick();
    end
    check("rnd_qa_empty", qa.size(), 0);
    check("rnd_qb_empty", qb.size(), 0);
    check("rnd_o_drained", o_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
